fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 15'h0000, meaning first fetch halfword address.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_raddr  output  15 [15:1]  instruction memory read address.
REQ-006 SHALL have port mem_rdata  input  16  read data, valid one cycle after its mem_raddr.
REQ-007 SHALL have port redirect  input  1  flush-and-redirect request from execute.
REQ-008 SHALL have port redirect_pc  input  15 [15:1]  new fetch address, used when redirect=1.
REQ-009 SHALL have port out_valid  output  1  head entry is valid for decode.
REQ-010 SHALL have port out_inst  output  16  head instruction.
REQ-011 SHALL have port out_pc  output  15 [15:1]  address of out_inst.
REQ-012 SHALL have port out_ready  input  1  decode accepts head; pop when out_valid & out_ready.
REQ-013 SHALL have port count  output  5  current number of stored entries.

Function
REQ-014 SHALL hold fetch_pc and issue a read (mem_raddr=fetch_pc, fetch_pc<=fetch_pc+1) each cycle that count + inflight - pop < DEPTH and redirect=0.
REQ-015 SHALL track one in-flight read (inflight flag + its pc); on the following cycle push {mem_rdata, pc} at the FIFO tail unless squashed.
REQ-016 SHALL drive mem_raddr=fetch_pc on non-issuing cycles; the returning data SHALL be ignored (inflight=0).
REQ-017 SHALL, on redirect=1: empty the FIFO, squash the in-flight read, drive mem_raddr=redirect_pc, mark it in-flight, set fetch_pc<=redirect_pc+1.
REQ-018 SHALL give redirect priority over pop and push in the same cycle; out_ready is ignored that cycle.
REQ-019 SHALL allow simultaneous push and pop at any occupancy; count unchanged.
REQ-020 SHALL never overflow: push at count==DEPTH is impossible by REQ-014; a violation is an assertion failure.
REQ-021 SHALL wrap fetch_pc 15'h7FFF+1 to 15'h0000, with no other effect.
REQ-022 SHALL present out_inst/out_pc from the FIFO head; out_valid = (count!=0), unless REQ-028 applies.
REQ-023 SHALL keep out_inst/out_pc stable while out_valid=1 and out_ready=0.
REQ-024 SHALL reach out_valid at T+2 after a redirect at T (issue T, push T+1, visible T+2), without bypass.
REQ-025 SHALL sustain one instruction per cycle when out_ready is held high.

Reset
REQ-026 SHALL, while rst_n=0: fetch_pc=RESET_PC, inflight=0, FIFO pointers=0, count=0, out_valid=0, mem_raddr=RESET_PC; out_inst/out_pc are don't-care.
REQ-027 SHALL, when rst_n asserts mid-operation, discard all entries and any in-flight read immediately; the first issue is on the first rising edge with rst_n=1.

Configuration
REQ-028 SHALL, with FETCH_QUEUE_BYPASS_EN defined, forward returning mem_rdata directly to out_inst/out_pc with out_valid=1 when count==0 and an unsquashed read returns; if out_ready=1 that cycle the entry is consumed and not pushed. Redirect latency then becomes T+1.
REQ-029 SHALL, without FETCH_QUEUE_BYPASS_EN, output only from the FIFO head per REQ-022/REQ-024.

Verification
REQ-030 Reset release, mem returns pc-tagged data, out_ready=1 -> out_pc 0,1,2,3... one per cycle from cycle 2 (cycle 1 with bypass).
REQ-031 out_ready=0 for 10 cycles, DEPTH=4 -> count reaches 4, issues stop, out_pc stays 0; out_ready=1 -> pops resume with no gap or duplicate.
REQ-032 redirect=1, redirect_pc=15'h0100 while count=3 and a read in flight -> count=0 next cycle, squashed data never output, out_pc=15'h0100 at T+2 (T+1 with bypass).
REQ-033 redirect and out_valid&out_ready in the same cycle -> no pop observed, count=0, next output is redirect_pc.
REQ-034 redirect_pc=15'h7FFE, out_ready=1 -> out_pc sequence 7FFE, 7FFF, 0000, 0001.
REQ-035 rst_n pulsed low for 1 cycle with count=2 -> out_valid=0 and count=0 at once, restart from RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- bundles the instruction-memory read port, the execute
// redirect request and the decode-side handshake of the fetch queue.
//
//   mem_raddr   [15:1]  instruction memory halfword read address
//   mem_rdata   [15:0]  read data, returned one cycle after its address
//   redirect            flush-and-redirect request from execute
//   redirect_pc [15:1]  new fetch address, used when redirect=1
//   out_valid           head entry valid for decode
//   out_inst    [15:0]  head instruction
//   out_pc      [15:1]  address of out_inst
//   out_ready           decode accepts the head entry
//   count       [4:0]   number of stored entries
//
// Modport master is the fetch queue; modport slave is its environment
// (memory + execute + decode).
interface fetch_queue_if;
  logic [15:1] mem_raddr;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:1] redirect_pc;
  logic        out_valid;
  logic [15:0] out_inst;
  logic [15:1] out_pc;
  logic        out_ready;
  logic [4:0]  count;

  modport master (
    output mem_raddr, out_valid, out_inst, out_pc, count,
    input  mem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  mem_raddr, out_valid, out_inst, out_pc, count,
    output mem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction prefetch queue. Issues sequential halfword
// reads to a one-cycle-latency instruction memory, tags each returning word
// with its address and queues it for decode. A redirect from execute flushes
// the queue, squashes the outstanding read and restarts fetch at redirect_pc.
//
// Parameters:
//   DEPTH     queue entries (power of 2, 2..16)
//   RESET_PC  first fetch halfword address after reset
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       fetch_queue_if.master (memory, redirect and decode signals)
//
// Build option: define FETCH_QUEUE_BYPASS_EN to forward a returning read
// straight to the output when the queue is empty (redirect-to-valid latency
// drops from two cycles to one). Without it, output comes only from the
// queue head.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input logic           clk,
  input logic           rst_n,
  fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);

  logic [15:1]   fetch_pc;
  logic          inflight;
  logic [15:1]   infl_pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    count_q;
  logic [15:0]   q_inst [DEPTH];
  logic [15:1]   q_pc   [DEPTH];

  logic          head_vld;
  logic          byp_vld;
  logic          pop;
  logic          byp_take;
  logic          push;
  logic          issue;
  logic [5:0]    occ;

  always_comb begin
    head_vld = (count_q != 5'd0);
`ifdef FETCH_QUEUE_BYPASS_EN
    // A returning read that is not being squashed can go straight out when
    // the queue has nothing older to present.
    byp_vld  = inflight && !head_vld && !bus.redirect;
`else
    byp_vld  = 1'b0;
`endif
    pop      = head_vld && bus.out_ready && !bus.redirect;
    byp_take = byp_vld && bus.out_ready;
    push     = inflight && !bus.redirect && !byp_take;
    // Occupancy after this cycle if no new read were issued; a new read
    // is only allowed when its data is guaranteed a slot next cycle.
    occ      = {1'b0, count_q} + {5'd0, inflight} - {5'd0, (pop | byp_take)};
    issue    = !bus.redirect && (occ < 6'(DEPTH));
  end

  assign bus.mem_raddr = (bus.redirect && rst_n) ? bus.redirect_pc : fetch_pc;
  assign bus.out_valid = head_vld || byp_vld;
  assign bus.out_inst  = byp_vld ? bus.mem_rdata : q_inst[rd_ptr];
  assign bus.out_pc    = byp_vld ? infl_pc : q_pc[rd_ptr];
  assign bus.count     = count_q;

  // Control state: fetch pointer, in-flight flag, queue pointers, occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= 5'd0;
    end else if (bus.redirect) begin
      // The redirect target is read this very cycle, so it is in flight.
      fetch_pc <= bus.redirect_pc + 15'd1;
      inflight <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= 5'd0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + 15'd1;
      inflight <= issue;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Data path: in-flight address tag and queue storage
  always_ff @(posedge clk) begin
    if (bus.redirect)
      infl_pc <= bus.redirect_pc;
    else if (issue)
      infl_pc <= fetch_pc;
    if (push) begin
      q_inst[wr_ptr] <= bus.mem_rdata;
      q_pc[wr_ptr]   <= infl_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == 5'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- directed bench for fetch_queue (DEPTH=4, RESET_PC=0).
// A behavioural memory returns a pc-derived word one cycle after each
// address. Stimulus loads the expected pc sequence into a scoreboard queue;
// an independent monitor pops and compares every accepted output.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(4), .RESET_PC(15'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_pops = 0;
  logic [14:0] exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] inst_of(input logic [14:0] pc);
    return {pc, 1'b0} ^ 16'hC3A5;
  endfunction

  // Instruction memory: one-cycle read latency.
  always @(posedge clk) bus.mem_rdata <= inst_of(bus.mem_raddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic load_seq(input logic [14:0] start);
    logic [14:0] pc;
    exp_q.delete();
    pc = start;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(pc);
      pc = pc + 15'd1;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !bus.redirect) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        chk("sb_empty", {17'd0, bus.out_pc}, 32'hFFFF_FFFF);
      end else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", bus.out_pc, e);
        chk("sb_inst", bus.out_inst, inst_of(e));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 15'h0;
    bus.out_ready = 1'b0;
    exp_q.delete();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_raddr", bus.mem_raddr, 15'h0000);

    // Release reset with decode always ready: pc 0,1,2,...
    load_seq(15'h0000);
    @(posedge clk); #1;           // C0
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("c0_valid", bus.out_valid, 0);
    @(negedge clk);               // C1
    chk("c1_valid", bus.out_valid, BYP);
    @(negedge clk);               // C2
    chk("c2_valid", bus.out_valid, 1);

    // Backpressure for ten cycles C8..C17
    repeat (6) @(posedge clk);    // E8
    #1 bus.out_ready = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);               // C16
    chk("bp_raddr_c16", bus.mem_raddr, BYP ? 15'd11 : 15'd10);
    @(negedge clk);               // C17
    chk("bp_count", bus.count, 4);
    chk("bp_raddr_c17", bus.mem_raddr, BYP ? 15'd11 : 15'd10);
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_head_pc", bus.out_pc, BYP ? 15'd7 : 15'd6);

    // One pop, then redirect with count=3 and a read in flight
    @(posedge clk); #1;           // C18
    bus.out_ready = 1'b1;
    @(posedge clk); #1;           // C19
    bus.out_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 15'h0100;
    load_seq(15'h0100);
    @(negedge clk);
    chk("redir_pre_count", bus.count, 3);
    chk("redir_raddr", bus.mem_raddr, 15'h0100);
    @(posedge clk); #1;           // C20
    bus.redirect = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("redir_t1_count", bus.count, 0);
    chk("redir_t1_valid", bus.out_valid, BYP);
    @(negedge clk);               // C21
    chk("redir_t2_valid", bus.out_valid, 1);
    chk("redir_t2_pc", bus.out_pc, BYP ? 15'h0101 : 15'h0100);

    // Redirect in the same cycle as a would-be pop
    repeat (5) @(posedge clk); #1; // C26
    bus.redirect = 1'b1;
    bus.redirect_pc = 15'h02AA;
    load_seq(15'h02AA);
    @(negedge clk);
    chk("rp_valid", bus.out_valid, !BYP);
    chk("rp_count", bus.count, BYP ? 0 : 1);
    @(posedge clk); #1;           // C27
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("rp_after_count", bus.count, 0);
    @(negedge clk);               // C28
    chk("rp_first_pc", bus.out_pc, BYP ? 15'h02AB : 15'h02AA);

    // Address wrap 7FFE,7FFF,0000,0001
    repeat (2) @(posedge clk); #1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 15'h7FFE;
    load_seq(15'h7FFE);
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    repeat (8) @(posedge clk);

    // Mid-operation reset pulse with two entries stored
    #1 bus.out_ready = 1'b0;
    repeat (BYP ? 2 : 1) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_count", bus.count, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    load_seq(15'h0000);
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_count", bus.count, 0);
    chk("arst_raddr", bus.mem_raddr, 15'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("total_pops_min", (n_pops >= 20), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
